// File: rtl/ula_pipe.sv
// ula_pipe -- two-stage pipelined 74181-style ALU, WIDTH bits wide.
//
// The word is built from 4-bit slices. Each slice produces a 74181 group
// propagate/generate pair, and a 74182-style lookahead network turns them
// into the carry entering every slice. Stage 1 registers the per-bit terms
// and the slice carries. Stage 2 ripples carries inside each slice, forms
// the result and registers it together with the flags.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready is combinational)
//   a, b                 WIDTH-bit operands
//   s, m, c_in           74181 function select, mode (1 = logic), carry in
//   acc_sel              (ULA_ACC_EN only) use the accumulator as operand A
//   out_valid/out_ready  result handshake
//   f                    WIDTH-bit result
//   c_out, a_eq_b, p, g, ovf  carry out, all-ones, group P/G, overflow
//
// Optional feature macro: ULA_ACC_EN (accumulator operand with hazard
// interlock). Without it the block is a plain pipelined ALU.

module ula_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
`ifdef ULA_ACC_EN
  input  logic             acc_sel,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             p,
  output logic             g,
  output logic             ovf
);

  localparam int NS = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("ula_pipe: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic             s2_adv, s1_adv, in_fire, out_fire;
  logic [WIDTH-1:0] op_a, bit_p, bit_g;
  logic [NS-1:0]    slice_p, slice_g;
  logic [NS:0]      look_c;
  logic             word_p, word_g;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_bp_q, s1_bp_d, s1_bg_q, s1_bg_d;
  logic [NS-1:0]    s1_c_q, s1_c_d;
  logic             s1_cout_q, s1_cout_d, s1_p_q, s1_p_d;
  logic             s1_g_q, s1_g_d, s1_m_q, s1_m_d;

  logic [WIDTH-1:0] bit_c, half, res;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_f_q, s2_f_d;
  logic             s2_cout_q, s2_cout_d, s2_eq_q, s2_eq_d;
  logic             s2_p_q, s2_p_d, s2_g_q, s2_g_d, s2_ovf_q, s2_ovf_d;

`ifdef ULA_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  // Handshake. With the accumulator, an acc_sel operation must wait until
  // the pipeline is empty so the accumulator holds the previous result.
  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = s1_valid_q & s2_adv;
    in_ready = !s1_valid_q | s1_adv;
`ifdef ULA_ACC_EN
    if (in_valid && acc_sel && (s1_valid_q || s2_valid_q)) in_ready = 1'b0;
`endif
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid_q & out_ready;
  end

  // Per-bit 74181 terms: the arithmetic result is bit_p + bit_g + c_in,
  // and bit_g is always a subset of bit_p.
  always_comb begin
    op_a = a;
`ifdef ULA_ACC_EN
    if (acc_sel) op_a = acc_q;
`endif
    bit_p = op_a | ({WIDTH{s[0]}} & b) | ({WIDTH{s[1]}} & ~b);
    bit_g = ({WIDTH{s[3]}} & op_a & b) | ({WIDTH{s[2]}} & op_a & ~b);
    for (int k = 0; k < NS; k++) begin
      slice_p[k] = &bit_p[4*k +: 4];
      slice_g[k] = bit_g[4*k+3]
                 | (bit_p[4*k+3] & bit_g[4*k+2])
                 | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
                 | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
    end
  end

  // Lookahead carries in sum-of-products form: every slice carry is a
  // two-level function of the slice P/G terms and c_in.
  always_comb begin
    logic gen_term, prop_term;
    gen_term  = 1'b0;
    prop_term = 1'b1;
    look_c    = '0;
    look_c[0] = c_in & ~m;
    for (int k = 0; k < NS; k++) begin
      gen_term  = 1'b0;
      prop_term = 1'b1;
      for (int j = k; j >= 0; j--) begin
        gen_term  = gen_term | (slice_g[j] & prop_term);
        prop_term = prop_term & slice_p[j];
      end
      look_c[k+1] = gen_term | (prop_term & look_c[0]);
    end
    word_g = gen_term;
    word_p = prop_term;
  end

  always_comb begin
    s1_valid_d = in_fire | (s1_valid_q & ~s1_adv);
    s1_bp_d    = s1_bp_q;
    s1_bg_d    = s1_bg_q;
    s1_c_d     = s1_c_q;
    s1_cout_d  = s1_cout_q;
    s1_p_d     = s1_p_q;
    s1_g_d     = s1_g_q;
    s1_m_d     = s1_m_q;
    if (in_fire) begin
      s1_bp_d   = bit_p;
      s1_bg_d   = bit_g;
      s1_c_d    = look_c[NS-1:0];
      s1_cout_d = look_c[NS] & ~m;
      s1_p_d    = ~m & word_p & ~word_g;
      s1_g_d    = ~m & word_g;
      s1_m_d    = m;
    end
  end

  // Carries inside each slice ripple from the registered slice carry-in.
  // Logic mode outputs the inverted half-sum, which gives the 74181 table.
  always_comb begin
    logic c;
    c     = 1'b0;
    bit_c = '0;
    for (int k = 0; k < NS; k++) begin
      c = s1_c_q[k];
      for (int i = 0; i < 4; i++) begin
        bit_c[4*k+i] = c;
        c = s1_bg_q[4*k+i] | (s1_bp_q[4*k+i] & c);
      end
    end
    half = s1_bp_q & ~s1_bg_q;
    res  = s1_m_q ? ~half : (half ^ bit_c);
  end

  always_comb begin
    s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
    s2_f_d     = s2_f_q;
    s2_cout_d  = s2_cout_q;
    s2_eq_d    = s2_eq_q;
    s2_p_d     = s2_p_q;
    s2_g_d     = s2_g_q;
    s2_ovf_d   = s2_ovf_q;
    if (s1_adv) begin
      s2_f_d    = res;
      s2_cout_d = s1_cout_q;
      s2_eq_d   = &res;
      s2_p_d    = s1_p_q;
      s2_g_d    = s1_g_q;
      s2_ovf_d  = ~s1_m_q & (bit_c[WIDTH-1] ^ s1_cout_q);
    end
  end

`ifdef ULA_ACC_EN
  always_comb acc_d = out_fire ? s2_f_q : acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bp_q    <= '0;
      s1_bg_q    <= '0;
      s1_c_q     <= '0;
      s1_cout_q  <= 1'b0;
      s1_p_q     <= 1'b0;
      s1_g_q     <= 1'b0;
      s1_m_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_f_q     <= '0;
      s2_cout_q  <= 1'b0;
      s2_eq_q    <= 1'b0;
      s2_p_q     <= 1'b0;
      s2_g_q     <= 1'b0;
      s2_ovf_q   <= 1'b0;
`ifdef ULA_ACC_EN
      acc_q      <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bp_q    <= s1_bp_d;
      s1_bg_q    <= s1_bg_d;
      s1_c_q     <= s1_c_d;
      s1_cout_q  <= s1_cout_d;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_m_q     <= s1_m_d;
      s2_valid_q <= s2_valid_d;
      s2_f_q     <= s2_f_d;
      s2_cout_q  <= s2_cout_d;
      s2_eq_q    <= s2_eq_d;
      s2_p_q     <= s2_p_d;
      s2_g_q     <= s2_g_d;
      s2_ovf_q   <= s2_ovf_d;
`ifdef ULA_ACC_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign f         = s2_f_q;
  assign c_out     = s2_cout_q;
  assign a_eq_b    = s2_eq_q;
  assign p         = s2_p_q;
  assign g         = s2_g_q;
  assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_ula_pipe.sv
// Testbench for ula_pipe (WIDTH=8). The driver pushes the expected result
// of each accepted operation into a queue; a monitor compares whatever the
// DUT presents against the head of that queue and pops on transfer.
module tb_ula_pipe;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             a_eq_b;
    logic             p;
    logic             g;
    logic             ovf;
  } exp_t;

  logic             clk, rst, in_valid, in_ready, m, c_in;
  logic             out_valid, out_ready, c_out, a_eq_b, p, g, ovf;
  logic [WIDTH-1:0] a, b, f;
  logic [3:0]       s;
`ifdef ULA_ACC_EN
  logic             acc_sel;
`endif

  exp_t exp_q[$];
  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   rdy_mode      = 0;

  ula_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
`ifdef ULA_ACC_EN
    .acc_sel(acc_sel),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .c_out(c_out),
    .a_eq_b(a_eq_b), .p(p), .g(g), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the 74181 active-high data table, arithmetic done as X + Y + c_in
  // on plain integers ("minus 1" is adding all ones).
  function automatic exp_t ref_model(logic [7:0] ra, logic [7:0] rb,
                                     logic [3:0] rs, logic rm, logic rc);
    exp_t e;
    logic [7:0] na, nb, x, y;
    logic [8:0] sum, gsum, psum;
    logic [7:0] lo;
    e  = '0;
    na = ~ra;
    nb = ~rb;
    x  = 8'h00;
    y  = 8'h00;
    if (rm) begin
      case (rs)
        4'h0: e.f = na;
        4'h1: e.f = ~(ra | rb);
        4'h2: e.f = na & rb;
        4'h3: e.f = 8'h00;
        4'h4: e.f = ~(ra & rb);
        4'h5: e.f = nb;
        4'h6: e.f = ra ^ rb;
        4'h7: e.f = ra & nb;
        4'h8: e.f = na | rb;
        4'h9: e.f = ~(ra ^ rb);
        4'hA: e.f = rb;
        4'hB: e.f = ra & rb;
        4'hC: e.f = 8'hFF;
        4'hD: e.f = ra | nb;
        4'hE: e.f = ra | rb;
        default: e.f = ra;
      endcase
    end else begin
      case (rs)
        4'h0: begin x = ra;        y = 8'h00;     end
        4'h1: begin x = ra | rb;   y = 8'h00;     end
        4'h2: begin x = ra | nb;   y = 8'h00;     end
        4'h3: begin x = 8'hFF;     y = 8'h00;     end
        4'h4: begin x = ra;        y = ra & nb;   end
        4'h5: begin x = ra | rb;   y = ra & nb;   end
        4'h6: begin x = ra;        y = nb;        end
        4'h7: begin x = ra & nb;   y = 8'hFF;     end
        4'h8: begin x = ra;        y = ra & rb;   end
        4'h9: begin x = ra;        y = rb;        end
        4'hA: begin x = ra | nb;   y = ra & rb;   end
        4'hB: begin x = ra & rb;   y = 8'hFF;     end
        4'hC: begin x = ra;        y = ra;        end
        4'hD: begin x = ra | rb;   y = ra;        end
        4'hE: begin x = ra | nb;   y = ra;        end
        default: begin x = ra;     y = 8'hFF;     end
      endcase
      sum     = {1'b0, x} + {1'b0, y} + 9'(rc);
      gsum    = {1'b0, x} + {1'b0, y};
      psum    = {1'b0, x} + {1'b0, y} + 9'd1;
      lo      = {1'b0, x[6:0]} + {1'b0, y[6:0]} + 8'(rc);
      e.f     = sum[7:0];
      e.c_out = sum[8];
      e.g     = gsum[8];
      e.p     = psum[8] & ~gsum[8];
      e.ovf   = lo[7] ^ sum[8];
    end
    e.a_eq_b = (e.f == 8'hFF);
    return e;
  endfunction

  function automatic exp_t mk_exp(logic [7:0] ef, logic ec, logic eq,
                                  logic ep, logic eg, logic eo);
    exp_t e;
    e.f = ef; e.c_out = ec; e.a_eq_b = eq; e.p = ep; e.g = eg; e.ovf = eo;
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v,
                               input logic [3:0] ts, input logic tm, input logic tc,
                               input bit use_const, input exp_t econst);
    exp_t e;
    int   waited;
    e        = use_const ? econst : ref_model(ta, tb_v, ts, tm, tc);
    a        = ta;
    b        = tb_v;
    s        = ts;
    m        = tm;
    c_in     = tc;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1) begin
      waited++;
      if (waited > 200) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL accept_timeout: in_ready=%b for 200 cycles, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t act;
    act = {f, c_out, a_eq_b, p, g, ovf};
    n_vectors++;
    if (exp_q.size() == 0) begin
      n_miscompares++;
      $display("[TB] FAIL unexpected_output: got f=%h with out_valid=1, required no output", f);
    end else if (act !== exp_q[0]) begin
      n_miscompares++;
      $display("[TB] FAIL result: got f=%h c=%b eq=%b p=%b g=%b ovf=%b, required f=%h c=%b eq=%b p=%b g=%b ovf=%b",
               act.f, act.c_out, act.a_eq_b, act.p, act.g, act.ovf,
               exp_q[0].f, exp_q[0].c_out, exp_q[0].a_eq_b, exp_q[0].p, exp_q[0].g, exp_q[0].ovf);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic checkReset(input string name);
    exp_t act;
    act = {f, c_out, a_eq_b, p, g, ovf};
    checkBit({name, "_out_valid"}, out_valid, 1'b0);
    checkBit({name, "_in_ready"}, in_ready, 1'b1);
    n_vectors++;
    if (act !== '0) begin
      n_miscompares++;
      $display("[TB] FAIL %s_outputs: got %h, required 0", name, act);
    end
  endtask

  task automatic waitEmpty(input string name, input int limit);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      @(posedge clk);
      w++;
    end
    n_vectors++;
    if (exp_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL %s: %0d results outstanding, required 0", name, exp_q.size());
    end
  endtask

  // Consumer: out_ready changes only just after a rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: the head of the queue must be presented (and held) until it transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1) begin
        checkOutput();
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h7F;
      3:       return 8'h80;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    logic [7:0] sa, sb;
    logic [3:0] ss;
    logic       sm, sc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
`ifdef ULA_ACC_EN
    acc_sel = 1'b0;
`endif
    #12;
    checkReset("reset_init");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8'hA5, 8'h5A, 4'b1001, 1'b0, 1'b1, 1'b1, mk_exp(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    applyStimulus(8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0, 1'b1, mk_exp(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    applyStimulus(8'h10, 8'h01, 4'b0110, 1'b0, 1'b1, 1'b1, mk_exp(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    applyStimulus(8'hF0, 8'hFF, 4'b0110, 1'b1, 1'b0, 1'b1, mk_exp(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(8'hF0, 8'hFF, 4'b1011, 1'b1, 1'b1, 1'b1, mk_exp(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    applyStimulus(8'h3C, 8'h3C, 4'b1001, 1'b1, 1'b0, 1'b1, mk_exp(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(8'hF0, 8'h0F, 4'b1110, 1'b1, 1'b1, 1'b1, mk_exp(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(8'h5A, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b1, mk_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    waitEmpty("directed_drain", 50);

    // Backpressure: two ops fill the pipe, the third must be refused.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(pick_operand(), pick_operand(), 4'b1001, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(pick_operand(), pick_operand(), 4'b0110, 1'b0, 1'b0, 1'b0, '0);
    sa = pick_operand(); sb = pick_operand();
    a = sa; b = sb; s = 4'b1100; m = 1'b0; c_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checkBit("in_ready_stall", in_ready, 1'b0);
    repeat (4) @(negedge clk);
    checkBit("in_ready_still_stalled", in_ready, 1'b0);
    rdy_mode = 0;
    applyStimulus(sa, sb, 4'b1100, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(pick_operand(), pick_operand(), 4'b0011, 1'b1, 1'b0, 1'b0, '0);
    waitEmpty("backpressure_drain", 50);

    // Asynchronous reset with two operations in flight.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(8'h12, 8'h34, 4'b1001, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(8'hFE, 8'hFE, 4'b1001, 1'b1, 1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    checkReset("reset_async");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    checkBit("no_stale_output", out_valid, 1'b0);
    @(posedge clk);
    #1;

`ifdef ULA_ACC_EN
    applyStimulus(8'h05, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, mk_exp(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    acc_sel = 1'b1;
    a = 8'hEE; b = 8'h03; s = 4'b1001; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checkBit("acc_interlock", in_ready, 1'b0);
    applyStimulus(8'hEE, 8'h03, 4'b1001, 1'b0, 1'b0, 1'b1, mk_exp(8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    acc_sel = 1'b0;
    waitEmpty("acc_drain", 50);
`endif

    // Randomized traffic with random consumer stalls and input gaps.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      sa = pick_operand();
      sb = pick_operand();
      ss = 4'($urandom());
      sm = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      applyStimulus(sa, sb, ss, sm, sc, 1'b0, '0);
    end
    rdy_mode = 0;
    waitEmpty("final_drain", 300);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
